cube_frame_scanner: RTL and testbench

//  Reader/decoder counterpart to the cube-net framebuffer writer. On a start pulse, walks
//  the 54 sticker cells of the 64x48 mini framebuffer (top-left cell of each 2x2 block),

---
 rtl/cube_frame_scanner.sv | 226 ++++++++++++++++++++++
 tb/tb_cube_frame_scanner.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cube_frame_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : cube_frame_scanner
//  Purpose  : Walks the 54 sticker cells of the 64x48 cube-net framebuffer,
//             decodes each RGB word to a 3-bit sticker code, un-remaps net
//             order to cube order and commits a packed 162-bit cube state.
//  Options  : CUBE_SCAN_COMPARE_EN - per-sticker compare against 'expected',
//             reported through mismatch_cnt (tied to 0 when undefined).
//  Revision : 1.0 - initial release
// ============================================================================
module cube_frame_scanner #(
    parameter int RD_LAT = 2,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              fb_req,
    input  logic              fb_gnt,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [23:0]       fb_q,
    input  logic [161:0]      expected,
    output logic [161:0]      cube_state,
    output logic              busy,
    output logic              done,
    output logic              decode_err,
    output logic [5:0]        mismatch_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [5:0] LAST_S   = 6'd53;
    localparam logic [5:0] MAX_MISS = 6'd54;

    state_t              state;
    logic [5:0]          s;             // next sticker (net order) to read
    logic                issue;
    logic [RD_LAT-1:0]   vld_pipe;      // read-in-flight markers
    logic [5:0]          tag_pipe [RD_LAT];
    logic                cap_vld;       // captured word waiting to be written
    logic                cap_last;
    logic [2:0]          cap_code;
    logic [5:0]          cap_k;
    logic [7:0]          cap_idx;
    logic [161:0]        shadow;
    logic [161:0]        shadow_next;
    logic [5:0]          mm;
    logic [5:0]          mm_next;

    // Net-order sticker index -> framebuffer address of the top-left pixel
    // of its 2x2 block. Belt rows insert a one-pixel gap between faces.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [5:0] idx);
        logic [ADDR_W-1:0] base;
        logic [5:0]        sub;
        logic              belt;
        logic [7:0]        off;
        logic [7:0]        gap;
        base = '0;
        sub  = '0;
        belt = 1'b0;
        case (idx) inside
            [6'd0:6'd2]:   begin base = ADDR_W'(652);  sub = idx;         end
            [6'd3:6'd5]:   begin base = ADDR_W'(844);  sub = idx - 6'd3;  end
            [6'd6:6'd8]:   begin base = ADDR_W'(1036); sub = idx - 6'd6;  end
            [6'd9:6'd20]:  begin base = ADDR_W'(1282); sub = idx - 6'd9;  belt = 1'b1; end
            [6'd21:6'd32]: begin base = ADDR_W'(1474); sub = idx - 6'd21; belt = 1'b1; end
            [6'd33:6'd44]: begin base = ADDR_W'(1666); sub = idx - 6'd33; belt = 1'b1; end
            [6'd45:6'd47]: begin base = ADDR_W'(1932); sub = idx - 6'd45; end
            [6'd48:6'd50]: begin base = ADDR_W'(2124); sub = idx - 6'd48; end
            default:       begin base = ADDR_W'(2316); sub = idx - 6'd51; end
        endcase
        off = {1'b0, sub, 1'b0} + {2'b00, sub};
        if (!belt)
            gap = 8'd0;
        else if (sub >= 6'd9)
            gap = 8'd3;
        else if (sub >= 6'd6)
            gap = 8'd2;
        else if (sub >= 6'd3)
            gap = 8'd1;
        else
            gap = 8'd0;
        return base + ADDR_W'(off + gap);
    endfunction

    // Net order -> cube order. The middle belt band is stored row-major
    // across faces on screen but face-major in the cube state.
    function automatic logic [5:0] remap(input logic [5:0] sn);
        logic [5:0] k;
        case (sn) inside
            [6'd12:6'd14]: k = sn + 6'd6;
            [6'd15:6'd17]: k = sn + 6'd12;
            [6'd18:6'd20]: k = sn + 6'd18;
            [6'd21:6'd23]: k = sn - 6'd9;
            [6'd24:6'd26]: k = sn - 6'd3;
            [6'd27:6'd29]: k = sn + 6'd3;
            [6'd30:6'd32]: k = sn + 6'd9;
            [6'd33:6'd35]: k = sn - 6'd18;
            [6'd36:6'd38]: k = sn - 6'd12;
            [6'd39:6'd41]: k = sn - 6'd6;
            default:       k = sn;
        endcase
        return k;
    endfunction

    // Exact palette match; anything else is flagged as an invalid sticker.
    function automatic logic [2:0] decode(input logic [23:0] q);
        logic [2:0] c;
        case (q)
            24'hFFFFFF: c = 3'd0;
            24'hFF4000: c = 3'd1;
            24'h00FF00: c = 3'd2;
            24'hFF0000: c = 3'd3;
            24'h0000FF: c = 3'd4;
            24'hFFFF00: c = 3'd5;
            24'hFF00FF: c = 3'd6;
            default:    c = 3'd7;
        endcase
        return c;
    endfunction

    assign issue   = (state == ISSUE) && fb_gnt;
    assign fb_req  = (state == ISSUE);
    assign busy    = (state != IDLE);
    assign fb_addr = (state == ISSUE) ? cell_addr(s) : '0;
    assign cap_idx = {1'b0, cap_k, 1'b0} + {2'b00, cap_k};

    // Read-latency tracker plus one decode/remap stage ahead of the shadow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            for (int i = 0; i < RD_LAT; i++)
                tag_pipe[i] <= '0;
            cap_vld  <= 1'b0;
            cap_last <= 1'b0;
            cap_code <= '0;
            cap_k    <= '0;
        end else begin
            vld_pipe[0] <= issue;
            tag_pipe[0] <= s;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
            cap_vld  <= vld_pipe[RD_LAT-1];
            cap_last <= vld_pipe[RD_LAT-1] && (tag_pipe[RD_LAT-1] == LAST_S);
            cap_code <= decode(fb_q);
            cap_k    <= remap(tag_pipe[RD_LAT-1]);
        end
    end

    // Shadow state and miss count as they will be after the pending write.
    always_comb begin
        shadow_next = shadow;
        shadow_next[cap_idx +: 3] = cap_code;
`ifdef CUBE_SCAN_COMPARE_EN
        mm_next = mm;
        if ((expected[cap_idx +: 3] != cap_code) && (mm != MAX_MISS))
            mm_next = mm + 6'd1;
`else
        mm_next = '0;
`endif
    end

`ifndef CUBE_SCAN_COMPARE_EN
    logic unused_expected;
    assign unused_expected = ^expected;
`endif

    // Scan sequencer: issue reads, collect captures, commit on the last one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            s            <= '0;
            shadow       <= '0;
            cube_state   <= '0;
            done         <= 1'b0;
            decode_err   <= 1'b0;
            mm           <= '0;
            mismatch_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (cap_vld) begin
                shadow <= shadow_next;
                mm     <= mm_next;
                if (cap_code == 3'd7)
                    decode_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= ISSUE;
                        s          <= '0;
                        decode_err <= 1'b0;
                        mm         <= '0;
                    end
                end
                ISSUE: begin
                    if (fb_gnt) begin
                        s <= s + 6'd1;
                        if (s == LAST_S)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (cap_vld && cap_last) begin
                        state        <= DONE;
                        done         <= 1'b1;
                        cube_state   <= shadow_next;
                        mismatch_cnt <= mm_next;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cube_frame_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cube_frame_scanner
//  Purpose  : Directed self-checking bench for cube_frame_scanner with a
//             behavioural framebuffer of read latency RD_LAT.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cube_frame_scanner;

    localparam int RD_LAT = 2;
    localparam int ADDR_W = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              fb_gnt = 1'b1;
    logic              fb_req;
    logic [ADDR_W-1:0] fb_addr;
    logic [23:0]       fb_q;
    logic [161:0]      expected = '0;
    logic [161:0]      cube_state;
    logic              busy;
    logic              done;
    logic              decode_err;
    logic [5:0]        mismatch_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [23:0]  mem [0:32767];
    logic [23:0]  rd_pipe [RD_LAT];
    logic [23:0]  rgb [0:6] = '{24'hFFFFFF, 24'hFF4000, 24'h00FF00, 24'hFF0000,
                                24'h0000FF, 24'hFFFF00, 24'hFF00FF};
    int           addr_tab [54];
    int           net2cube [54];
    int           mid_cube [30] = '{18, 19, 20, 27, 28, 29, 36, 37, 38,
                                    12, 13, 14, 21, 22, 23, 30, 31, 32, 39, 40, 41,
                                    15, 16, 17, 24, 25, 26, 33, 34, 35};
    int           colr [54];
    logic [161:0] exp_state;
    logic [161:0] mid_state;
    logic         mid_err;
    int           issue_cnt = 0;
    int           bad_addr = 0;
    int           done_cnt = 0;
    int           gnt_mode = 0;
    int           lat;
    int           d0;

    cube_frame_scanner #(.RD_LAT(RD_LAT), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .fb_req       (fb_req),
        .fb_gnt       (fb_gnt),
        .fb_addr      (fb_addr),
        .fb_q         (fb_q),
        .expected     (expected),
        .cube_state   (cube_state),
        .busy         (busy),
        .done         (done),
        .decode_err   (decode_err),
        .mismatch_cnt (mismatch_cnt)
    );

    always #5 clk = ~clk;

    // Framebuffer: address sampled on an edge, data valid RD_LAT edges later.
    always @(posedge clk) begin
        rd_pipe[0] <= mem[fb_addr];
        for (int i = 1; i < RD_LAT; i++)
            rd_pipe[i] <= rd_pipe[i-1];
    end
    assign fb_q = rd_pipe[RD_LAT-1];

    // Issued-read and done-pulse monitor, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (fb_req && fb_gnt) begin
                if (issue_cnt >= 54 || fb_addr != ADDR_W'(addr_tab[issue_cnt]))
                    bad_addr++;
                issue_cnt++;
            end
            if (done)
                done_cnt++;
        end
    end

    // Grant driver: steady high, or toggling every three cycles.
    initial begin
        int gcnt;
        gcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (gnt_mode != 0) begin
                gcnt++;
                if (gcnt == 3) begin
                    fb_gnt = ~fb_gnt;
                    gcnt   = 0;
                end
            end else begin
                fb_gnt = 1'b1;
            end
        end
    end

    task automatic check_val(input string tag, input logic [161:0] got, input logic [161:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Paint the sticker cells from colr[] and build the matching cube state.
    task automatic load_frame();
        for (int sn = 0; sn < 54; sn++)
            mem[addr_tab[sn]] = rgb[colr[net2cube[sn]]];
        for (int k = 0; k < 54; k++)
            exp_state[3*k +: 3] = 3'(colr[k]);
    endtask

    // Start pulse sampled at edge 0; lat = edges after edge 0 until done seen.
    task automatic run_scan(input int repulse_at, input int abort_at, output int n);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (n < 2000) begin
            @(posedge clk);
            n++;
            #1;
            start = (n == repulse_at);
            if (n == 10) begin
                mid_state = cube_state;
                mid_err   = decode_err;
            end
            if (n == abort_at) begin
                rst = 1'b0;
                #1;
                check_val("abort_cube", cube_state, '0);
                check_val("abort_busy", busy, 0);
                check_val("abort_req", fb_req, 0);
                check_val("abort_addr", fb_addr, 0);
                check_val("abort_err", decode_err, 0);
                @(posedge clk);
                #1 rst = 1'b1;
                return;
            end
            @(negedge clk);
            if (done)
                break;
        end
    endtask

    initial begin
        int sn;
        for (int a = 0; a < 32768; a++)
            mem[a] = 24'h000000;
        sn = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                addr_tab[sn] = 652 + 192*r + 3*c;
                sn++;
            end
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 12; c++) begin
                addr_tab[sn] = 1282 + 192*r + 3*c + c/3;
                sn++;
            end
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                addr_tab[sn] = 1932 + 192*r + 3*c;
                sn++;
            end
        for (int i = 0; i < 54; i++)
            net2cube[i] = (i >= 12 && i <= 41) ? mid_cube[i-12] : i;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_cube", cube_state, '0);
        check_val("rst_req", fb_req, 0);
        check_val("rst_addr", fb_addr, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_err", decode_err, 0);
        check_val("rst_mm", mismatch_cnt, 0);
        rst = 1'b1;

        // All-white frame: exact latency, all zero codes, every address once
        for (int k = 0; k < 54; k++) colr[k] = 0;
        load_frame();
        expected = exp_state;
        issue_cnt = 0; bad_addr = 0; d0 = done_cnt;
        run_scan(0, 0, lat);
        check_val("white_lat", lat, 57);
        check_val("white_cube", cube_state, '0);
        check_val("white_err", decode_err, 0);
        check_val("white_busy", busy, 1);
        @(posedge clk); #1;
        check_val("white_pulse", done, 0);
        check_val("white_idle", busy, 0);
        check_val("white_issues", issue_cnt, 54);
        check_val("white_addr", bad_addr, 0);
        check_val("white_dones", done_cnt - d0, 1);

        // Solved cube, face codes 0..5
        for (int k = 0; k < 54; k++) colr[k] = k / 9;
        load_frame();
        expected = exp_state;
        run_scan(0, 0, lat);
        check_val("solved_mid", mid_state, '0);
        check_val("solved_cube", cube_state, exp_state);
        check_val("solved_mm", mismatch_cnt, 0);

        // Distinct per-sticker pattern using all seven codes
        for (int k = 0; k < 54; k++) colr[k] = (k * 5) % 7;
        load_frame();
        expected = exp_state;
        run_scan(0, 0, lat);
        check_val("pat_cube", cube_state, exp_state);
        check_val("pat_err", decode_err, 0);

        // Off-palette word at s=10 (cell 1285, cube sticker 10)
        mem[1285] = 24'h123456;
        exp_state[32:30] = 3'b111;
        run_scan(0, 0, lat);
        check_val("bad_cube", cube_state, exp_state);
        check_val("bad_err", decode_err, 1);

        // Grant toggling: same result, no lost or extra reads; err cleared on start
        load_frame();
        gnt_mode = 1;
        issue_cnt = 0; bad_addr = 0;
        run_scan(0, 0, lat);
        gnt_mode = 0;
        check_val("tog_finish", lat < 2000, 1);
        check_val("tog_err_clr", mid_err, 0);
        check_val("tog_cube", cube_state, exp_state);
        check_val("tog_issues", issue_cnt, 54);
        check_val("tog_addr", bad_addr, 0);

        // Start re-pulsed mid-scan is ignored
        @(posedge clk);
        d0 = done_cnt;
        issue_cnt = 0;
        run_scan(20, 0, lat);
        check_val("rep_lat", lat, 57);
        repeat (80) @(posedge clk);
        #1;
        check_val("rep_dones", done_cnt - d0, 1);
        check_val("rep_issues", issue_cnt, 54);
        check_val("rep_busy", busy, 0);

        // Reset mid-scan aborts with no commit
        d0 = done_cnt;
        run_scan(0, 30, lat);
        repeat (100) @(posedge clk);
        #1;
        check_val("abort_dones", done_cnt - d0, 0);
        check_val("abort_cube2", cube_state, '0);
        check_val("abort_busy2", busy, 0);

        // Expected differs at stickers 0 and 53
        expected = exp_state;
        expected[2:0]     = expected[2:0] ^ 3'b001;
        expected[161:159] = expected[161:159] ^ 3'b010;
        run_scan(0, 0, lat);
        check_val("cmp_cube", cube_state, exp_state);
`ifdef CUBE_SCAN_COMPARE_EN
        check_val("cmp_mm", mismatch_cnt, 2);
`else
        check_val("cmp_mm", mismatch_cnt, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
